// File: rtl/stream_block_framer_pkg.sv
// framer_pkg: shared types and constants for stream_block_framer.
// Holds the FSM state enum, header/trailer magic words and field offsets.
package framer_pkg;

    typedef enum logic [1:0] {IDLE, PAY, TRL} state_t;

    localparam logic [31:0] HDR_MAGIC = 32'hC0DE_5EED;
    localparam logic [31:0] TRL_MAGIC = 32'hEDD0_C0DE;

    localparam int MAGIC_LSB     = 0;
    localparam int HDR_SEQ_LSB   = 32;
    localparam int HDR_BEATS_LSB = 64;
    localparam int TRL_CNT_LSB   = 32;
    localparam int TRL_BYTES_LSB = 40;

endpackage

// File: rtl/stream_block_framer_if.sv
// stream_block_framer_if: AXI-Stream style bundle used on both sides of the framer.
// Signals: data, tvalid, tlast, tkeep, user ({is_trailer, is_header}), tready.
// master drives data/tvalid/tlast/tkeep/user and samples tready; slave is the mirror
// (user is not carried on the input side).
interface stream_block_framer_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TKEEP_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]  data;
    logic                   tvalid;
    logic                   tlast;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic [1:0]             user;
    logic                   tready;

    modport master (output data, tvalid, tlast, tkeep, user, input tready);
    modport slave  (input data, tvalid, tlast, tkeep, output tready);
endinterface

// File: rtl/stream_block_framer_popcount.sv
// keep_popcount: combinational count of set bits in a byte-enable vector.
// Ports: i_keep (WIDTH byte enables), o_cnt (number of enabled bytes, 6 bits).
module keep_popcount #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_keep,
    output logic [5:0]       o_cnt
);
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < WIDTH; i++) o_cnt = o_cnt + 6'(i_keep[i]);
    end
endmodule

// File: rtl/stream_block_framer.sv
// stream_block_framer: cuts a raw stream into blocks of at most BLOCK_BEATS beats,
// prepends a header beat per block and, with STREAM_FRAMER_TRAILER_EN defined,
// appends a trailer beat carrying the beat and byte counts.
// Ports: clk; reset (async, active-low); s (slave stream in, s.tready out);
//        m (master stream out, all m.* driven from one output register).
// Macro: STREAM_FRAMER_TRAILER_EN enables the TRL state, byte counting and m.user[1].
module stream_block_framer
    import framer_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int TKEEP_WIDTH = 32,
    parameter int BLOCK_BEATS = 16,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    stream_block_framer_if.slave   s,
    stream_block_framer_if.master  m
);
    state_t                 r_state, w_state;
    logic [31:0]            r_seq, w_seq;
    logic [CNT_WIDTH-1:0]   r_beat, w_beat;
    logic [DATA_WIDTH-1:0]  r_data, w_data, w_hdr;
    logic [TKEEP_WIDTH-1:0] r_keep, w_keep;
    logic                   r_valid, w_valid;
    logic                   r_last, w_last;
    logic                   r_is_hdr, w_is_hdr;
    logic                   w_load_ok, w_take, w_end;

    // The output register may be reloaded when empty or being drained this cycle.
    assign w_load_ok = !r_valid || m.tready;
    assign s.tready  = (r_state == PAY) && w_load_ok;
    assign w_take    = s.tvalid && s.tready;
    // Input tlast and the beat limit coinciding still make a single block end.
    assign w_end     = s.tlast || (r_beat == CNT_WIDTH'(BLOCK_BEATS - 1));

    always_comb begin
        w_hdr = '0;
        w_hdr[MAGIC_LSB +: 32]     = HDR_MAGIC;
        w_hdr[HDR_SEQ_LSB +: 32]   = r_seq;
        w_hdr[HDR_BEATS_LSB +: 8]  = 8'(BLOCK_BEATS);
    end

`ifdef STREAM_FRAMER_TRAILER_EN
    logic [15:0]           r_bytes, w_bytes;
    logic [5:0]            w_pop;
    logic                  r_is_trl, w_is_trl;
    logic [DATA_WIDTH-1:0] w_trl;

    keep_popcount #(.WIDTH(TKEEP_WIDTH)) u_pop (.i_keep(s.tkeep), .o_cnt(w_pop));

    // Counters already include the final payload beat when TRL is entered.
    always_comb begin
        w_trl = '0;
        w_trl[MAGIC_LSB +: 32]     = TRL_MAGIC;
        w_trl[TRL_CNT_LSB +: 8]    = 8'(r_beat);
        w_trl[TRL_BYTES_LSB +: 16] = r_bytes;
    end

    assign m.user = {r_is_trl, r_is_hdr};
`else
    assign m.user = {1'b0, r_is_hdr};
`endif

    always_comb begin
        w_state  = r_state;
        w_seq    = r_seq;
        w_beat   = r_beat;
        w_data   = r_data;
        w_keep   = r_keep;
        w_last   = r_last;
        w_is_hdr = r_is_hdr;
        // Valid only falls through a handshake; a new load below re-asserts it.
        w_valid  = r_valid && !m.tready;
`ifdef STREAM_FRAMER_TRAILER_EN
        w_bytes  = r_bytes;
        w_is_trl = r_is_trl;
`endif
        case (r_state)
            IDLE: begin
                if (s.tvalid && w_load_ok) begin
                    w_valid  = 1'b1;
                    w_data   = w_hdr;
                    w_keep   = '1;
                    w_last   = 1'b0;
                    w_is_hdr = 1'b1;
                    w_beat   = '0;
`ifdef STREAM_FRAMER_TRAILER_EN
                    w_bytes  = '0;
                    w_is_trl = 1'b0;
`endif
                    w_state  = PAY;
                end
            end
            PAY: begin
                if (w_take) begin
                    w_valid  = 1'b1;
                    w_data   = s.data;
                    w_keep   = s.tkeep;
                    w_is_hdr = 1'b0;
                    w_beat   = r_beat + 1'b1;
`ifdef STREAM_FRAMER_TRAILER_EN
                    w_bytes  = r_bytes + 16'(w_pop);
                    w_is_trl = 1'b0;
                    w_last   = 1'b0;
                    if (w_end) w_state = TRL;
`else
                    w_last   = w_end;
                    if (w_end) begin
                        w_seq   = r_seq + 1'b1;
                        w_state = IDLE;
                    end
`endif
                end
            end
`ifdef STREAM_FRAMER_TRAILER_EN
            TRL: begin
                if (w_load_ok) begin
                    w_valid  = 1'b1;
                    w_data   = w_trl;
                    w_keep   = '1;
                    w_last   = 1'b1;
                    w_is_hdr = 1'b0;
                    w_is_trl = 1'b1;
                    w_seq    = r_seq + 1'b1;
                    w_state  = IDLE;
                end
            end
`endif
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_seq    <= '0;
            r_beat   <= '0;
            r_data   <= '0;
            r_keep   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_is_hdr <= 1'b0;
`ifdef STREAM_FRAMER_TRAILER_EN
            r_bytes  <= '0;
            r_is_trl <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_seq    <= w_seq;
            r_beat   <= w_beat;
            r_data   <= w_data;
            r_keep   <= w_keep;
            r_valid  <= w_valid;
            r_last   <= w_last;
            r_is_hdr <= w_is_hdr;
`ifdef STREAM_FRAMER_TRAILER_EN
            r_bytes  <= w_bytes;
            r_is_trl <= w_is_trl;
`endif
        end
    end

    assign m.data   = r_data;
    assign m.tkeep  = r_keep;
    assign m.tvalid = r_valid;
    assign m.tlast  = r_last;
endmodule
